// File: rtl/gray_counter_nbit.sv
// gray_counter_nbit: up/down binary counter with a registered Gray-code mirror.
// The counter has a synchronous load, a combinational terminal-count flag and
// a one-cycle wrap pulse.
// Optional build macro GRAY_LOAD_EN: when defined, load_val_in is a Gray code
// and is decoded to binary before it is loaded. When undefined, load_val_in is
// loaded as binary with no decode logic.
module gray_counter_nbit #(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             en_in,
  input  logic             up_dn_in,
  input  logic             load_in,
  input  logic [WIDTH-1:0] load_val_in,
  output logic [WIDTH-1:0] bin_out,
  output logic [WIDTH-1:0] gray_out,
  output logic             tc_out,
  output logic             wrap_out
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] bin_reg;
  logic [WIDTH-1:0] bin_next;
  logic [WIDTH-1:0] gray_reg;
  logic [WIDTH-1:0] gray_next;
  logic             wrap_reg;
  logic             wrap_next;
  logic [WIDTH-1:0] load_bin;
  logic             tc;

`ifdef GRAY_LOAD_EN
  // Gray-to-binary decode: each binary bit is the XOR of all Gray bits at or
  // above it. Every bit has its own reduction, so there is no ripple chain.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_gray2bin
      assign load_bin[gi] = ^load_val_in[WIDTH-1:gi];
    end
  endgenerate
`else
  // The load value is already binary.
  assign load_bin = load_val_in;
`endif

  // Terminal count: the next enabled step wraps. It is masked while a load is pending.
  always_comb begin
    tc = 1'b0;
    if (en_in && !load_in) begin
      tc = up_dn_in ? (&bin_reg) : (~|bin_reg);
    end
  end

  // Next-state selection: a load has priority over a step, and a step has priority over hold.
  always_comb begin
    bin_next  = bin_reg;
    wrap_next = 1'b0;
    if (load_in) begin
      bin_next = load_bin;
    end else if (en_in) begin
      bin_next  = up_dn_in ? (bin_reg + ONE) : (bin_reg - ONE);
      wrap_next = tc;
    end
    gray_next = bin_next ^ (bin_next >> 1);
  end

  // Register binary, Gray and wrap together, so that Gray and binary always match.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      bin_reg  <= '0;
      gray_reg <= '0;
      wrap_reg <= 1'b0;
    end else begin
      bin_reg  <= bin_next;
      gray_reg <= gray_next;
      wrap_reg <= wrap_next;
    end
  end

  assign bin_out  = bin_reg;
  assign gray_out = gray_reg;
  assign wrap_out = wrap_reg;
  assign tc_out   = tc;

endmodule

// File: doc/gray_counter_nbit.md
GRAY_COUNTER_NBIT -- requirements
Module: gray_counter_nbit

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; legal range 2..32.
REQ-002 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-003 rst_n_in  input  1  reset, asynchronous, active-low.
REQ-004 en_in  input  1  count enable; one step per clock while high.
REQ-005 up_dn_in  input  1  direction: 1 = increment, 0 = decrement.
REQ-006 load_in  input  1  synchronous load strobe.
REQ-007 load_val_in  input  WIDTH  value loaded when load_in is high.
REQ-008 bin_out  output  WIDTH  registered binary count.
REQ-009 gray_out  output  WIDTH  registered Gray code of the count.
REQ-010 tc_out  output  1  terminal count: combinational, high when the next enabled step in the current direction wraps.
REQ-011 wrap_out  output  1  registered one-cycle pulse, high in the cycle after a wrap occurred.

Function
REQ-012 Priority at each rising edge SHALL be: load_in, then en_in, then hold.
REQ-013 load_in=1 SHALL set bin_out to the load value on that edge, regardless of en_in and up_dn_in; wrap_out SHALL be 0 on the next cycle.
REQ-014 load_in=0 with en_in=1 and up_dn_in=1 SHALL set bin_out to bin_out+1 modulo 2^WIDTH.
REQ-015 load_in=0 with en_in=1 and up_dn_in=0 SHALL set bin_out to bin_out-1 modulo 2^WIDTH.
REQ-016 load_in=0 with en_in=0 SHALL hold bin_out and gray_out, and drive wrap_out to 0.
REQ-017 gray_out SHALL equal the next binary value XOR (next binary value >> 1).
REQ-018 gray_out SHALL be registered on the same edge as bin_out, so gray_out always matches bin_out with zero relative latency.
REQ-019 Between consecutive enabled steps, gray_out SHALL change in exactly one bit, including across wrap.
REQ-020 tc_out SHALL equal en_in AND ((up_dn_in AND bin_out==all-ones) OR (NOT up_dn_in AND bin_out==0)).
REQ-021 tc_out SHALL be masked to 0 while load_in is high.
REQ-022 wrap_out SHALL be 1 for exactly one cycle after an edge at which tc_out was 1 and the step was taken.
REQ-023 Changing up_dn_in between cycles SHALL take effect on the very next enabled edge, with no dead cycle.

Reset
REQ-024 While rst_n_in is low: bin_out=0, gray_out=0 and wrap_out=0, immediately and without any clock.
REQ-025 tc_out during reset SHALL follow REQ-020 with bin_out=0.
REQ-026 Reset asserted mid-count SHALL abandon any pending load or step.
REQ-027 After rst_n_in deasserts, the first rising edge SHALL obey REQ-012 normally.

Configuration
REQ-028 Macro GRAY_LOAD_EN:
- Defined: load_val_in SHALL be interpreted as a Gray code. It SHALL be converted to binary (b[WIDTH-1]=g[WIDTH-1]; b[i]=b[i+1] XOR g[i]) before loading. gray_out after the load SHALL therefore equal load_val_in.
- Not defined: load_val_in SHALL be loaded as binary directly, and no conversion logic SHALL be present.

Verification
REQ-029 WIDTH=4, reset then en_in=1, up_dn_in=1 for 16 clocks -> bin_out 0..15 then 0; gray_out 0000,0001,0011,0010,...,1000,0000; one bit changes per step; wrap_out pulses once after 15->0.
REQ-030 WIDTH=4, load 0, then en_in=1, up_dn_in=0 -> bin_out 15, gray_out 1000; tc_out=1 while bin_out=0 before the step; wrap_out=1 for one cycle.
REQ-031 bin_out=7 with load_in=1, load_val_in=0101, en_in=1 -> without GRAY_LOAD_EN: bin_out=5, gray_out=0111; with GRAY_LOAD_EN: bin_out=6, gray_out=0101; tc_out=0 during load.
REQ-032 Count to 9, drop rst_n_in between clock edges -> bin_out, gray_out and wrap_out go to 0 at once; the first edge after release with en_in=1, up_dn_in=1 gives bin_out=1.
REQ-033 bin_out=3, en_in=0 for 5 clocks, then up_dn_in toggles each cycle with en_in=1 -> hold at 3, then 4,3,4,3; wrap_out stays 0.
REQ-034 WIDTH=8, count up from 254 -> 255 (gray 10000000), then 0; tc_out high at 255; wrap_out pulse follows.
